// File: rtl/ascon_stream_loader_if.sv
//==============================================================================
// Module   : ascon_stream_loader_if
// Brief    : Byte streams plus wide Ascon core buses for ascon_stream_loader.
//            The master modport is the loader; slave is source/sink/core side.
//            ASCON_LOADER_TAG_CHECK_EN adds the tag_match signal.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface ascon_stream_loader_if #(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 40
);
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_decrypt;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic [K-1:0] core_key;
    logic [127:0] core_nonce;
    logic [L-1:0] core_ad;
    logic [Y-1:0] core_data;
    logic         core_decrypt;
    logic         core_start;
    logic [Y-1:0] core_out;
    logic [127:0] core_tag;
    logic         core_ready;
`ifdef ASCON_LOADER_TAG_CHECK_EN
    logic         tag_match;
`endif

    modport master (
`ifdef ASCON_LOADER_TAG_CHECK_EN
        output tag_match,
`endif
        input  in_valid, in_data, in_decrypt, out_ready,
        input  core_out, core_tag, core_ready,
        output in_ready, out_valid, out_data, out_last,
        output core_key, core_nonce, core_ad, core_data, core_decrypt, core_start
    );

    modport slave (
`ifdef ASCON_LOADER_TAG_CHECK_EN
        input  tag_match,
`endif
        output in_valid, in_data, in_decrypt, out_ready,
        output core_out, core_tag, core_ready,
        input  in_ready, out_valid, out_data, out_last,
        input  core_key, core_nonce, core_ad, core_data, core_decrypt, core_start
    );
endinterface

`default_nettype wire

// File: rtl/ascon_stream_loader.sv
//==============================================================================
// Module   : ascon_stream_loader
// Brief    : Deserialises key/nonce/AD/data bytes onto the Ascon core inputs,
//            runs the core and serialises output data + tag as bytes.
//            Optional macro ASCON_LOADER_TAG_CHECK_EN: expected-tag compare.
// Revision : 1.0
//==============================================================================
`default_nettype none

module ascon_stream_loader #(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 40
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ascon_stream_loader_if.master  io_bus
);
    localparam int c_KB        = K / 8;
    localparam int c_LB        = L / 8;
    localparam int c_YB        = Y / 8;
    localparam int c_N_IN_BASE = c_KB + 16 + c_LB + c_YB;
`ifdef ASCON_LOADER_TAG_CHECK_EN
    localparam int c_N_IN_MAX  = c_N_IN_BASE + 16;
`else
    localparam int c_N_IN_MAX  = c_N_IN_BASE;
`endif
    localparam int c_N_OUT     = c_YB + 16;
    localparam int c_ICW       = $clog2(c_N_IN_MAX + 1);
    localparam int c_OCW       = $clog2(c_N_OUT + 1);
    localparam int c_SRW       = Y + 128;

    localparam logic [c_ICW-1:0] c_KEY_END   = c_ICW'(c_KB);
    localparam logic [c_ICW-1:0] c_NONCE_END = c_ICW'(c_KB + 16);
    localparam logic [c_ICW-1:0] c_AD_END    = c_ICW'(c_KB + 16 + c_LB);
    localparam logic [c_ICW-1:0] c_DATA_END  = c_ICW'(c_N_IN_BASE);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_SEND    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_ICW-1:0]   r_icnt;
    logic [c_OCW-1:0]   r_ocnt;
    logic [K-1:0]       r_key;
    logic [127:0]       r_nonce;
    logic [L-1:0]       r_ad;
    logic [Y-1:0]       r_data;
    logic               r_decrypt;
    logic [c_SRW-1:0]   r_out_sr;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_core_start;
`ifdef ASCON_LOADER_TAG_CHECK_EN
    logic [127:0]       r_exp_tag;
    logic               r_tag_match;
`endif

    logic [c_ICW-1:0]   w_in_last_idx;
    logic [c_OCW-1:0]   w_out_last_idx;
    logic [c_OCW-1:0]   w_ocnt_nxt;
    logic               w_in_fire;
    logic               w_out_fire;

    // r_decrypt is stale only at byte 0, which can never be the last input byte.
    always_comb begin
        w_in_last_idx  = c_ICW'(c_N_IN_BASE - 1);
        w_out_last_idx = c_OCW'(c_N_OUT - 1);
`ifdef ASCON_LOADER_TAG_CHECK_EN
        if (r_decrypt) begin
            w_in_last_idx  = c_ICW'(c_N_IN_MAX - 1);
            w_out_last_idx = c_OCW'(c_YB - 1);
        end
`endif
    end

    assign w_in_fire  = io_bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & io_bus.out_ready;
    assign w_ocnt_nxt = r_ocnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_icnt       <= '0;
            r_ocnt       <= '0;
            r_key        <= '0;
            r_nonce      <= '0;
            r_ad         <= '0;
            r_data       <= '0;
            r_decrypt    <= 1'b0;
            r_out_sr     <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_core_start <= 1'b0;
`ifdef ASCON_LOADER_TAG_CHECK_EN
            r_exp_tag    <= '0;
            r_tag_match  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_icnt <= r_icnt + 1'b1;
                        if (r_icnt == '0) begin
                            r_decrypt <= io_bus.in_decrypt;
                        end
                        // Shifting each field left puts the first byte at the MSB end.
                        if (r_icnt < c_KEY_END) begin
                            r_key <= K'({r_key, io_bus.in_data});
                        end else if (r_icnt < c_NONCE_END) begin
                            r_nonce <= 128'({r_nonce, io_bus.in_data});
                        end else if (r_icnt < c_AD_END) begin
                            r_ad <= L'({r_ad, io_bus.in_data});
                        end else if (r_icnt < c_DATA_END) begin
                            r_data <= Y'({r_data, io_bus.in_data});
                        end
`ifdef ASCON_LOADER_TAG_CHECK_EN
                        else begin
                            r_exp_tag <= 128'({r_exp_tag, io_bus.in_data});
                        end
`endif
                        if (r_icnt == w_in_last_idx) begin
                            r_in_ready   <= 1'b0;
                            r_core_start <= 1'b1;
                            r_state      <= S_START;
`ifdef ASCON_LOADER_TAG_CHECK_EN
                            r_tag_match  <= 1'b0;
`endif
                        end
                    end
                end

                S_START: begin
                    r_core_start <= 1'b0;
                    r_state      <= S_WAIT;
                end

                S_WAIT: begin
                    if (io_bus.core_ready) begin
                        r_out_sr    <= {io_bus.core_out, io_bus.core_tag};
                        r_ocnt      <= '0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (w_out_last_idx == '0);
`ifdef ASCON_LOADER_TAG_CHECK_EN
                        r_tag_match <= r_decrypt && (io_bus.core_tag == r_exp_tag);
`endif
                        r_state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (w_out_fire) begin
                        r_out_sr <= r_out_sr << 8;
                        r_ocnt   <= w_ocnt_nxt;
                        if (r_ocnt == w_out_last_idx) begin
                            r_out_valid  <= 1'b0;
                            r_out_last   <= 1'b0;
                            r_core_start <= 1'b1;
                            r_state      <= S_RELEASE;
                        end else begin
                            r_out_last <= (w_ocnt_nxt == w_out_last_idx);
                        end
                    end
                end

                S_RELEASE: begin
                    // The second start pulse returns the core from DONE to IDLE.
                    r_core_start <= 1'b0;
                    r_icnt       <= '0;
                    r_in_ready   <= 1'b1;
                    r_state      <= S_LOAD;
                end

                default: begin
                    r_state      <= S_LOAD;
                    r_core_start <= 1'b0;
                    r_in_ready   <= 1'b1;
                    r_out_valid  <= 1'b0;
                    r_out_last   <= 1'b0;
                    r_icnt       <= '0;
                end
            endcase
        end
    end

    assign io_bus.in_ready     = r_in_ready;
    assign io_bus.out_valid    = r_out_valid;
    assign io_bus.out_data     = r_out_sr[c_SRW-1 -: 8];
    assign io_bus.out_last     = r_out_last;
    assign io_bus.core_key     = r_key;
    assign io_bus.core_nonce   = r_nonce;
    assign io_bus.core_ad      = r_ad;
    assign io_bus.core_data    = r_data;
    assign io_bus.core_decrypt = r_decrypt;
    assign io_bus.core_start   = r_core_start;
`ifdef ASCON_LOADER_TAG_CHECK_EN
    assign io_bus.tag_match    = r_tag_match;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ascon_stream_loader.sv
//==============================================================================
// Module   : tb_ascon_stream_loader
// Brief    : Self-checking bench for ascon_stream_loader with a stand-in core
//            (keystream XOR cipher) and a byte-level reference model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_ascon_stream_loader;
    localparam int K     = 128;
    localparam int L     = 40;
    localparam int Y     = 40;
    localparam int KB    = K / 8;
    localparam int LB    = L / 8;
    localparam int YB    = Y / 8;
    localparam int N_OUT = YB + 16;
`ifdef ASCON_LOADER_TAG_CHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif
    localparam int DEC_NOUT = TC ? YB : N_OUT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_stream_loader_if #(.K(K), .L(L), .Y(Y)) bus();
    ascon_stream_loader #(.K(K), .L(L), .Y(Y)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stand-in cipher: keystream XOR for data, tag over key/nonce/AD/ciphertext.
    function automatic logic [Y+127:0] core_fn(input logic [K-1:0] k, input logic [127:0] n,
                                               input logic [L-1:0] a, input logic [Y-1:0] d,
                                               input logic dec);
        logic [Y-1:0] ks, o, ct;
        logic [127:0] t;
        ks = k[127:88] ^ n[39:0] ^ a;
        o  = d ^ ks;
        ct = dec ? d : o;
        t  = k ^ {n[63:0], n[127:64]} ^ {ct, a, 48'h0};
        return {o, t};
    endfunction

    // Core model: IDLE(0) -start-> BUSY(1) -latency-> DONE(2, ready) -start-> IDLE.
    int               core_st  = 0;
    int               core_lat = 0;
    int               core_err = 0;
    logic [Y+127:0]   core_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_st        <= 0;
            core_lat       <= 0;
            bus.core_ready <= 1'b0;
            bus.core_out   <= '0;
            bus.core_tag   <= '0;
        end else begin
            case (core_st)
                0: if (bus.core_start) begin
                    core_res <= core_fn(bus.core_key, bus.core_nonce, bus.core_ad,
                                        bus.core_data, bus.core_decrypt);
                    bus.core_out <= Y'($urandom);
                    bus.core_tag <= {$urandom, $urandom, $urandom, $urandom};
                    core_lat     <= int'($urandom_range(1, 4));
                    core_st      <= 1;
                end
                1: begin
                    if (bus.core_start) core_err <= core_err + 1;
                    if (core_lat <= 1) begin
                        {bus.core_out, bus.core_tag} <= core_res;
                        bus.core_ready <= 1'b1;
                        core_st        <= 2;
                    end else begin
                        core_lat <= core_lat - 1;
                    end
                end
                default: if (bus.core_start) begin
                    bus.core_ready <= 1'b0;
                    core_st        <= 0;
                end
            endcase
        end
    end

    int   start_pulses = 0;
    int   start_consec = 0;
    logic prev_start   = 1'b0;
    always @(posedge clk) begin
        if (bus.core_start) begin
            start_pulses <= start_pulses + 1;
            if (prev_start) start_consec <= start_consec + 1;
        end
        prev_start <= bus.core_start;
    end

    typedef struct {
        bit dec;
        bit from_prev;
        bit rnd;
        int gap_pct;
        int rmode;
        bit flip;
        int exp_nout;
        bit exp_tm;
    } vec_t;
    vec_t tbl[6];

    logic [7:0] f_key[KB], f_nonce[16], f_ad[LB], f_dat[YB], f_etag[16];
    logic [7:0] p_key[KB], p_nonce[16], p_ad[LB], p_ct[YB], p_tag[16];
    logic [7:0] got[64];

    task automatic send_bytes(input logic [7:0] q[$], input bit dec, input int gap_pct, input int nmax);
        int guard;
        for (int i = 0; i < nmax; i++) begin
            for (int g = 0; g < 3; g++) begin
                if (gap_pct == 0 || int'($urandom_range(0, 99)) >= gap_pct) break;
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                tick();
            end
            bus.in_valid   = 1'b1;
            bus.in_data    = q[i];
            bus.in_decrypt = (i == 0) ? dec : 1'($urandom);
            guard = 0;
            while (!bus.in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) begin
                chk("in_ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_msg(input vec_t v, input string nm);
        logic [K-1:0]     e_key;
        logic [127:0]     e_nonce;
        logic [L-1:0]     e_ad;
        logic [Y-1:0]     e_dat;
        logic [Y+127:0]   e_res;
        logic [7:0]       q[$];
        logic [7:0]       hold_d;
        int sp0, n, guard, cyc;
        bit done, hold, r;
        for (int i = 0; i < KB; i++) f_key[i]   = v.from_prev ? p_key[i]   : (v.rnd ? 8'($urandom) : 8'(i));
        for (int i = 0; i < 16; i++) f_nonce[i] = v.from_prev ? p_nonce[i] : (v.rnd ? 8'($urandom) : 8'(16 + i));
        for (int i = 0; i < LB; i++) f_ad[i]    = v.from_prev ? p_ad[i]    : (v.rnd ? 8'($urandom) : 8'(i));
        for (int i = 0; i < YB; i++) f_dat[i]   = v.from_prev ? p_ct[i]    : (v.rnd ? 8'($urandom) : 8'(i));
        for (int i = 0; i < 16; i++) f_etag[i]  = v.from_prev ? p_tag[i]   : 8'($urandom);
        if (v.flip) f_etag[15] = f_etag[15] ^ 8'h01;
        e_key = '0; e_nonce = '0; e_ad = '0; e_dat = '0;
        for (int i = 0; i < KB; i++) begin e_key   = {e_key[K-9:0], f_key[i]};     q.push_back(f_key[i]);   end
        for (int i = 0; i < 16; i++) begin e_nonce = {e_nonce[119:0], f_nonce[i]}; q.push_back(f_nonce[i]); end
        for (int i = 0; i < LB; i++) begin e_ad    = {e_ad[L-9:0], f_ad[i]};       q.push_back(f_ad[i]);    end
        for (int i = 0; i < YB; i++) begin e_dat   = {e_dat[Y-9:0], f_dat[i]};     q.push_back(f_dat[i]);   end
        if (TC && v.dec) for (int i = 0; i < 16; i++) q.push_back(f_etag[i]);
        e_res = core_fn(e_key, e_nonce, e_ad, e_dat, v.dec);

        sp0 = start_pulses;
        send_bytes(q, v.dec, v.gap_pct, q.size());
        chk({nm, "_start_after_last"}, bus.core_start, 1);
        chk({nm, "_no_early_start"}, start_pulses - sp0, 0);
        chk({nm, "_in_ready_low"}, bus.in_ready, 0);
        chk({nm, "_core_key"}, bus.core_key, e_key);
        chk({nm, "_core_nonce"}, bus.core_nonce, e_nonce);
        chk({nm, "_core_ad_data"}, {bus.core_ad, bus.core_data}, {e_ad, e_dat});
        chk({nm, "_core_decrypt"}, bus.core_decrypt, v.dec);

        n = 0; guard = 0; cyc = 0; done = 0; hold = 0; hold_d = '0;
        while (!done && guard < 400) begin
            case (v.rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom);
            endcase
            bus.out_ready = r;
            if (bus.out_valid && r) begin
                got[n] = bus.out_data;
                n++;
                if (bus.out_last) done = 1;
            end
            hold = bus.out_valid && !r;
            hold_d = bus.out_data;
            tick();
            cyc++;
            guard++;
            if (hold) chk({nm, "_stall_stable"}, {bus.out_valid, bus.out_data}, {1'b1, hold_d});
            if (n >= 64) break;
        end
        bus.out_ready = 1'b0;
        chk({nm, "_last_seen"}, done, 1);
        chk({nm, "_nout"}, n, v.exp_nout);
        for (int i = 0; i < n && i < v.exp_nout; i++)
            chk($sformatf("%s_byte%0d", nm, i), got[i], e_res[Y+127-8*i -: 8]);
        chk({nm, "_release_pulse"}, {bus.core_start, bus.out_valid, bus.out_last}, 3'b100);
        tick();
        chk({nm, "_back_to_load"}, {bus.in_ready, bus.core_start}, 2'b10);
        chk({nm, "_core_idle"}, core_st, 0);
        chk({nm, "_two_pulses"}, start_pulses - sp0, 2);
`ifdef ASCON_LOADER_TAG_CHECK_EN
        chk({nm, "_tag_match"}, bus.tag_match, v.exp_tm);
`endif
        if (!v.dec) begin
            p_key = f_key; p_nonce = f_nonce; p_ad = f_ad;
            for (int i = 0; i < YB; i++) p_ct[i]  = e_res[Y+127-8*i -: 8];
            for (int i = 0; i < 16; i++) p_tag[i] = e_res[127-8*i -: 8];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        tbl[0] = '{dec:1'b0, from_prev:1'b0, rnd:1'b0, gap_pct:0,  rmode:0, flip:1'b0, exp_nout:N_OUT,    exp_tm:1'b0};
        tbl[1] = '{dec:1'b1, from_prev:1'b1, rnd:1'b0, gap_pct:0,  rmode:0, flip:1'b0, exp_nout:DEC_NOUT, exp_tm:1'b1};
        tbl[2] = '{dec:1'b0, from_prev:1'b0, rnd:1'b1, gap_pct:0,  rmode:1, flip:1'b0, exp_nout:N_OUT,    exp_tm:1'b0};
        tbl[3] = '{dec:1'b0, from_prev:1'b0, rnd:1'b1, gap_pct:40, rmode:2, flip:1'b0, exp_nout:N_OUT,    exp_tm:1'b0};
        tbl[4] = '{dec:1'b1, from_prev:1'b1, rnd:1'b0, gap_pct:30, rmode:1, flip:1'b0, exp_nout:DEC_NOUT, exp_tm:1'b1};
        tbl[5] = '{dec:1'b1, from_prev:1'b1, rnd:1'b0, gap_pct:0,  rmode:2, flip:1'b1, exp_nout:DEC_NOUT, exp_tm:1'b0};

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_decrypt = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        #12;
        chk("reset_handshake", {bus.in_ready, bus.out_valid, bus.out_last, bus.core_start}, 4'b1000);
        chk("reset_core_key", bus.core_key, 0);
        chk("reset_core_bufs", {bus.core_nonce, bus.core_ad, bus.core_data, bus.core_decrypt}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) begin
            run_msg(tbl[t], $sformatf("vec%0d", t));
            if (t == 1) chk("dec_plaintext", {got[0], got[1], got[2], got[3], got[4]}, 40'h0001020304);
        end

        // Asynchronous reset part-way through a frame, then a clean frame.
        for (int i = 0; i < 42; i++) q.push_back(8'($urandom) | 8'h01);
        send_bytes(q, 1'b0, 0, 20);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {bus.in_ready, bus.out_valid, bus.out_last, bus.core_start}, 4'b1000);
        chk("midrst_core_key", bus.core_key, 0);
        chk("midrst_core_nonce", bus.core_nonce, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_msg(tbl[3], "after_rst");

        chk("core_protocol_errors", core_err, 0);
        chk("start_never_consecutive", start_consec, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
